aes128_round_engine: RTL
========================

Name: aes128_round_engine

Overview:
- Iterative AES-128 encryption datapath that sits directly downstream of the combinational key-expansion stage.
- Consumes the flat expanded-key bus (all Nr+1 round keys) and one 128-bit plaintext block; produces the 128-bit ciphertext.
- Executes one AES round per clock under a small FSM, with valid/ready handshakes on input and output.

Parameters:
- Nk, 4, key length in 32-bit words; only 4 is supported.
- Nr, 10, number of rounds; sets the fullkey width and the final-round index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext and fullkey are valid.
- in_ready  output  1  engine can accept a block; high only in IDLE.
- plaintext  input  [0:127]  input block; bit 0 is the MSB; byte k = bits [8k:8k+7].
- fullkey  input  [0:128*(Nr+1)-1]  expanded key; round key r = bits [128r : 128r+127]; round key 0 is the cipher key.
- out_valid  output  1  ciphertext is valid.
- out_ready  input  1  downstream accepts the ciphertext.
- ciphertext  output  [0:127]  result block; same byte order as plaintext.
- busy  output  1  high in ROUND or DONE.

Behaviour:
- State mapping: byte k maps to state row k%4, column k/4 (column-major, per FIPS-197).
- Reset (rst=1 at a clock edge): FSM=IDLE, round counter=0, state register=0, out_valid=0, busy=0, in_ready=1 in the cycle after reset. Reset overrides every other event and aborts an in-flight block; that block is never output.
- FSM IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: state <= plaintext ^ rk0; round <= 1; go to ROUND.
- FSM ROUND:
  - in_ready=0.
  - Each edge applies round `round` using rk[round].
  - For round 1..Nr-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[round]; round <= round+1.
  - For round == Nr: state <= ShiftRows(SubBytes(state)) ^ rk[Nr]; go to DONE.
- FSM DONE:
  - out_valid=1; ciphertext = state register.
  - On an edge with out_ready=1: go to IDLE, out_valid <= 0.
  - While out_ready=0, hold ciphertext and out_valid stable indefinitely.
- Latency: if the accept edge is T, out_valid rises after edge T+Nr (10 cycles for AES-128).
- Throughput: at most one block per Nr+2 cycles. There is no accept in DONE, even when out_ready=1 on the same edge.
- fullkey is not registered. The producer holds it stable from the accept edge through the final-round edge. plaintext is needed only on the accept edge.
- in_valid while busy is ignored; no data is captured and no error is flagged.
- ciphertext drives the state register at all times, so intermediate round values are visible. Consumers qualify it with out_valid.
- Round counter: 4 bits, range 1..Nr, no wrap.
- SubBytes: 16 parallel FIPS-197 forward S-box lookups, combinational.
- MixColumns: GF(2^8) with xtime (shift left by 1, XOR 0x1b if the MSB was set); matrix rows {02 03 01 01} rotated.
- Critical path: exactly one full round plus the key XOR per cycle.

Test Plan:
- FIPS-197 App. B: fullkey from key-expansion model of 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734; out_ready=1 -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept, high for one cycle.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: App. B vector with out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- Busy-drop: pulse in_valid with an all-zero plaintext during round 5 of an App. B run -> result still 3925841d..., no second out_valid.
- Mid-run reset: assert rst at round 4 -> next cycle out_valid=0, busy=0, in_ready=1. A fresh App. C.1 block then gives 69c4e0d8... exactly 10 cycles after accept.
- Back-to-back: two App. C.1 blocks with in_valid held high and out_ready=1 -> second accept occurs exactly Nr+2=12 cycles after the first, and both outputs are correct.

Source files
------------

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine: one full cipher round per clock.
// Takes the flat expanded-key bus from the key-expansion stage plus a
// plaintext block, and returns the ciphertext under valid/ready handshakes.
// Byte k of every 128-bit block sits at bits [8k:8k+7] and maps to state
// row k%4, column k/4.
module aes128_round_engine #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             plaintext,
  input  logic [0:128*(Nr+1)-1]    fullkey,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             ciphertext,
  output logic                     busy
);

  // For AES-128 the round-key width equals the cipher-key width.
  localparam int         RK_BITS    = 32 * Nk;
  localparam logic [3:0] LAST_ROUND = 4'(Nr);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // GF(2^8) multiply-by-two with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One cipher round without the key addition; the last round skips MixColumns.
  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    o = 128'd0;
    for (int k = 0; k < 16; k++) begin
      sb[k] = SBOX[s[8*k +: 8]];
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c + 1];
      a2 = sr[4*c + 2];
      a3 = sr[4*c + 3];
      if (last) begin
        o[32*c +: 32] = {a0, a1, a2, a3};
      end else begin
        o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return o;
  endfunction

  fsm_t             fsm_r, fsm_next_s;
  logic [3:0]       round_r, round_next_s;
  logic [0:127]     state_r, state_next_s;
  logic [0:127]     round_out_s;
  logic [0:RK_BITS-1] rk_s [0:Nr];
  logic             in_ready_r, busy_r, out_valid_r;

  // Slice the flat key bus into per-round keys.
  for (genvar g = 0; g <= Nr; g++) begin : g_rk
    assign rk_s[g] = fullkey[RK_BITS*g +: RK_BITS];
  end

  assign round_out_s = aes_round(state_r, round_r == LAST_ROUND);
  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign out_valid   = out_valid_r;
  assign ciphertext  = state_r;

  // Next-state, next-round and datapath update for the round FSM.
  always_comb begin
    fsm_next_s   = fsm_r;
    round_next_s = round_r;
    state_next_s = state_r;
    case (fsm_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = plaintext ^ rk_s[0];
          round_next_s = 4'd1;
          fsm_next_s   = ROUND;
        end else begin
          fsm_next_s   = IDLE;
        end
      end
      ROUND: begin
        state_next_s = round_out_s ^ rk_s[round_r];
        if (round_r == LAST_ROUND) begin
          fsm_next_s   = DONE;
        end else begin
          round_next_s = round_r + 4'd1;
        end
      end
      DONE: begin
        // No accept here: a new block can only enter from IDLE.
        if (out_ready) begin
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = DONE;
        end
      end
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
  end

  // State, counter, datapath and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      round_r     <= 4'd0;
      state_r     <= 128'd0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      fsm_r       <= fsm_next_s;
      round_r     <= round_next_s;
      state_r     <= state_next_s;
      in_ready_r  <= (fsm_next_s == IDLE);
      busy_r      <= (fsm_next_s != IDLE);
      out_valid_r <= (fsm_next_s == DONE);
    end
  end

endmodule
